msrv32_wr_en_ctrl: RTL and testbench



---
 rtl/msrv32_wr_en_ctrl.sv | 130 +++++++++++++
 tb/tb_msrv32_wr_en_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_wr_en_ctrl.sv
// Writeback write-enable controller: per-channel gating with stall masking, x0 suppression and a flush kill window.
// Optional statistics counters are built only when MSRV32_WR_EN_STATS_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | requests pass through, subject to flush/stall/x0 gating
// KILL  | all requests masked until kcnt expires without a new flush
module msrv32_wr_en_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int FLUSH_HOLD = 2,
  parameter int ADDR_W     = 5,
  parameter int CNT_W      = 16
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  input  logic                    flush_in,
  input  logic                    stall_in,
  input  logic [NUM_CH-1:0]       wr_en_req_in,
  input  logic [ADDR_W-1:0]       rd_addr_in,
  output logic [NUM_CH-1:0]       wr_en_out,
  output logic [ADDR_W-1:0]       rd_addr_out,
  output logic                    kill_active_out,
  output logic [NUM_CH*CNT_W-1:0] commit_cnt_out,
  output logic [CNT_W-1:0]        kill_cnt_out
);

  typedef enum logic {RUN = 1'b0, KILL = 1'b1} state_t;

  // kcnt counts the KILL cycles still to go after the current one, so the
  // window length including the flush cycle itself is FLUSH_HOLD.
  localparam bit         HAS_WINDOW = (FLUSH_HOLD > 1);
  localparam logic [3:0] KRELOAD    = HAS_WINDOW ? 4'(FLUSH_HOLD - 2) : 4'd0;

  state_t            state;
  logic [3:0]        kcnt;
  logic [NUM_CH-1:0] en_next;
  logic              killed;

  always_comb begin
    en_next = '0;
    if ((state == RUN) && !flush_in && !stall_in)
      en_next = wr_en_req_in;
    if (rd_addr_in == '0)
      en_next[0] = 1'b0;
    killed = (|wr_en_req_in) && (flush_in || (state == KILL));
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state           <= RUN;
      kcnt            <= 4'd0;
      kill_active_out <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush_in && HAS_WINDOW) begin
            state           <= KILL;
            kcnt            <= KRELOAD;
            kill_active_out <= 1'b1;
          end else begin
            kill_active_out <= 1'b0;
          end
        end
        KILL: begin
          if (flush_in) begin
            kcnt            <= KRELOAD;
            kill_active_out <= 1'b1;
          end else if (kcnt == 4'd0) begin
            state           <= RUN;
            kill_active_out <= 1'b0;
          end else begin
            kcnt            <= kcnt - 4'd1;
            kill_active_out <= 1'b1;
          end
        end
        default: begin
          state           <= RUN;
          kcnt            <= 4'd0;
          kill_active_out <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wr_en_out   <= '0;
      rd_addr_out <= '0;
    end else begin
      wr_en_out   <= en_next;
      rd_addr_out <= rd_addr_in;
    end
  end

`ifdef MSRV32_WR_EN_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] commit_cnt [NUM_CH];
  logic [CNT_W-1:0] kill_cnt;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int c = 0; c < NUM_CH; c++)
        commit_cnt[c] <= '0;
      kill_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (en_next[c] && (commit_cnt[c] != '1))
          commit_cnt[c] <= commit_cnt[c] + CNT_ONE;
      if (killed && (kill_cnt != '1))
        kill_cnt <= kill_cnt + CNT_ONE;
    end
  end

  always_comb begin
    commit_cnt_out = '0;
    for (int c = 0; c < NUM_CH; c++)
      commit_cnt_out[c*CNT_W +: CNT_W] = commit_cnt[c];
  end

  assign kill_cnt_out = kill_cnt;
`else
  logic unused_killed;
  assign unused_killed  = killed;
  assign commit_cnt_out = '0;
  assign kill_cnt_out   = '0;
`endif

endmodule

// File: tb/tb_msrv32_wr_en_ctrl.sv
// Self-checking bench for msrv32_wr_en_ctrl: vector table, corner sequences and random stimulus vs. a window model.
module tb_msrv32_wr_en_ctrl;

`ifdef MSRV32_WR_EN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, stall;
  logic [1:0] req;
  logic [4:0] addr;

  logic [1:0]  wen_a, wen_b, wen_c;
  logic [4:0]  ad_a, ad_b, ad_c;
  logic        ka_a, ka_b, ka_c;
  logic [31:0] cc_a, cc_b;
  logic [7:0]  cc_c;
  logic [15:0] kc_a, kc_b;
  logic [3:0]  kc_c;

  always #5 clk = ~clk;

  msrv32_wr_en_ctrl dut_a (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush), .stall_in(stall),
    .wr_en_req_in(req), .rd_addr_in(addr), .wr_en_out(wen_a), .rd_addr_out(ad_a),
    .kill_active_out(ka_a), .commit_cnt_out(cc_a), .kill_cnt_out(kc_a));

  msrv32_wr_en_ctrl #(.FLUSH_HOLD(4)) dut_b (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush), .stall_in(stall),
    .wr_en_req_in(req), .rd_addr_in(addr), .wr_en_out(wen_b), .rd_addr_out(ad_b),
    .kill_active_out(ka_b), .commit_cnt_out(cc_b), .kill_cnt_out(kc_b));

  msrv32_wr_en_ctrl #(.CNT_W(4)) dut_c (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush), .stall_in(stall),
    .wr_en_req_in(req), .rd_addr_in(addr), .wr_en_out(wen_c), .rd_addr_out(ad_c),
    .kill_active_out(ka_c), .commit_cnt_out(cc_c), .kill_cnt_out(kc_c));

  int nchk = 0;
  int nerr = 0;

  // Model: each flush at edge e masks edges e .. e+FH-1, tracked as an end edge.
  int fh [3]  = '{2, 4, 2};
  int cw [3]  = '{16, 16, 4};
  int edge_n  = 0;
  int kill_end [3];
  int m_en [3];
  int m_ka [3];
  int m_c0 [3];
  int m_c1 [3];
  int m_kc [3];
  int m_addr;

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit f, input bit s, input bit [1:0] q, input bit [4:0] a);
    for (int d = 0; d < 3; d++) begin
      int  cap;
      bit  masked;
      bit [1:0] en;
      cap = (1 << cw[d]) - 1;
      if (r) begin
        kill_end[d] = 0;
        m_en[d] = 0; m_ka[d] = 0;
        m_c0[d] = 0; m_c1[d] = 0; m_kc[d] = 0;
      end else begin
        masked = f || (edge_n < kill_end[d]);
        en = (masked || s) ? 2'b00 : q;
        if (a == 0) en[0] = 1'b0;
        if (f) kill_end[d] = edge_n + fh[d];
        m_ka[d] = (edge_n + 1 < kill_end[d]) ? 1 : 0;
        m_en[d] = en;
        if (q != 0 && masked && m_kc[d] < cap) m_kc[d]++;
        if (en[0] && m_c0[d] < cap) m_c0[d]++;
        if (en[1] && m_c1[d] < cap) m_c1[d]++;
      end
    end
    m_addr = r ? 0 : a;
    edge_n++;
  endtask

  function automatic int sx(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic check_models();
    check("a.en", wen_a, m_en[0]);  check("a.addr", ad_a, m_addr); check("a.kill_active", ka_a, m_ka[0]);
    check("a.commit0", cc_a[15:0], sx(m_c0[0])); check("a.commit1", cc_a[31:16], sx(m_c1[0]));
    check("a.kill_cnt", kc_a, sx(m_kc[0]));
    check("b.en", wen_b, m_en[1]);  check("b.addr", ad_b, m_addr); check("b.kill_active", ka_b, m_ka[1]);
    check("b.commit0", cc_b[15:0], sx(m_c0[1])); check("b.commit1", cc_b[31:16], sx(m_c1[1]));
    check("b.kill_cnt", kc_b, sx(m_kc[1]));
    check("c.en", wen_c, m_en[2]);  check("c.addr", ad_c, m_addr); check("c.kill_active", ka_c, m_ka[2]);
    check("c.commit0", cc_c[3:0], sx(m_c0[2])); check("c.commit1", cc_c[7:4], sx(m_c1[2]));
    check("c.kill_cnt", kc_c, sx(m_kc[2]));
  endtask

  task automatic step(input bit r, input bit f, input bit s, input bit [1:0] q, input bit [4:0] a);
    rst = r; flush = f; stall = s; req = q; addr = a;
    @(posedge clk);
    #1;
    model(r, f, s, q, a);
    check_models();
  endtask

  typedef struct {
    bit       rst, flush, stall;
    bit [1:0] req;
    bit [4:0] addr;
    bit [1:0] en;
    bit [4:0] aout;
    bit       ka;
    bit       chk;
    int       c0, c1, kc;
  } vec_t;

  vec_t tbl [18];

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; req = 2'b00; addr = 5'd0;

    //           rst flu stl req    addr   en     aout   ka chk c0 c1 kc
    tbl[0]  = '{1, 0, 0, 2'b00, 5'd0, 2'b00, 5'd0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 2'b11, 5'd5, 2'b11, 5'd5, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 2'b11, 5'd5, 2'b11, 5'd5, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 2'b11, 5'd5, 2'b11, 5'd5, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 2'b11, 5'd5, 2'b11, 5'd5, 0, 1, 4, 4, 0};
    tbl[5]  = '{0, 0, 0, 2'b11, 5'd0, 2'b10, 5'd0, 0, 1, 4, 5, 0};
    tbl[6]  = '{0, 1, 0, 2'b11, 5'd5, 2'b00, 5'd5, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 2'b11, 5'd5, 2'b00, 5'd5, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 2'b11, 5'd5, 2'b11, 5'd5, 0, 1, 5, 6, 2};
    tbl[9]  = '{0, 0, 1, 2'b11, 5'd7, 2'b00, 5'd7, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 2'b11, 5'd7, 2'b00, 5'd7, 0, 1, 5, 6, 2};
    tbl[11] = '{0, 0, 0, 2'b11, 5'd7, 2'b11, 5'd7, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 2'b11, 5'd3, 2'b00, 5'd3, 1, 1, 6, 7, 3};
    tbl[13] = '{0, 0, 0, 2'b01, 5'd3, 2'b00, 5'd3, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 2'b01, 5'd3, 2'b01, 5'd3, 0, 1, 7, 7, 4};
    tbl[15] = '{0, 1, 0, 2'b11, 5'd9, 2'b00, 5'd9, 1, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 2'b11, 5'd9, 2'b00, 5'd0, 0, 1, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 2'b11, 5'd4, 2'b11, 5'd4, 0, 1, 1, 1, 0};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].req, tbl[i].addr);
      check($sformatf("tbl%0d.en", i), wen_a, tbl[i].en);
      check($sformatf("tbl%0d.addr", i), ad_a, tbl[i].aout);
      check($sformatf("tbl%0d.kill_active", i), ka_a, tbl[i].ka);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d.commit0", i), cc_a[15:0], sx(tbl[i].c0));
        check($sformatf("tbl%0d.commit1", i), cc_a[31:16], sx(tbl[i].c1));
        check($sformatf("tbl%0d.kill_cnt", i), kc_a, sx(tbl[i].kc));
      end
    end

    // Back-to-back flush with FLUSH_HOLD=4: edges t..t+4 masked, t+5 enabled.
    step(1, 0, 0, 2'b00, 5'd0);
    step(0, 0, 0, 2'b11, 5'd5);
    step(0, 1, 0, 2'b11, 5'd5);
    check("b2b.t.en", wen_b, 0);
    step(0, 1, 0, 2'b11, 5'd5);
    check("b2b.t1.en", wen_b, 0);
    for (int k = 2; k <= 4; k++) begin
      step(0, 0, 0, 2'b11, 5'd5);
      check($sformatf("b2b.t%0d.en", k), wen_b, 0);
    end
    check("b2b.t4.kill_active", ka_b, 0);
    step(0, 0, 0, 2'b11, 5'd5);
    check("b2b.t5.en", wen_b, 3);

    // Reset during KILL, with flush on the same edge: reset wins.
    step(0, 1, 0, 2'b11, 5'd5);
    check("rstkill.pre.kill_active", ka_a, 1);
    step(1, 1, 0, 2'b11, 5'd5);
    check("rstkill.kill_active", ka_a, 0);
    check("rstkill.en", wen_a, 0);
    check("rstkill.kill_cnt", kc_a, 0);
    step(0, 0, 0, 2'b11, 5'd6);
    check("rstkill.first.en", wen_a, 3);

    // Saturation on the CNT_W=4 instance after 20 commits.
    step(1, 0, 0, 2'b00, 5'd0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 2'b11, 5'd5);
    check("sat.c.commit0", cc_c[3:0], STATS ? 15 : 0);
    check("sat.a.commit0", cc_a[15:0], STATS ? 20 : 0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      bit [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           2'($urandom_range(0, 3)), a);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
